instr_fetch_unit: RTL
=====================

# instr_fetch_unit

Instruction fetch and program-counter stage feeding the `Control_Unit` decoder. It owns the PC and runs a request/acknowledge fetch from instruction memory. It latches the fetched word and splits it into `OP_CODE`/`FUNCT_3`/`FUNCT_7`/register fields for the decoder and register file. When the datapath retires an instruction, it selects the next PC from the decoder's `PCS`/`BS` outputs and the ALU flags.

## Interface
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset.
- `ADDR_W`, default 32: PC / address width; PC arithmetic is modulo 2^ADDR_W.
- `CLK` in 1: rising-edge clock.
- `RST` in 1: reset RST, synchronous, active-high.
- `IMEM_REQ` out 1: fetch request to instruction memory.
- `IMEM_ADDR` out ADDR_W: fetch address; equals `PC`.
- `IMEM_ACK` in 1: memory returns `IMEM_RDATA` valid this cycle.
- `IMEM_RDATA` in 32: fetched instruction word.
- `EXEC_DONE` in 1: datapath has completed the current instruction (one-cycle pulse).
- `PCS` in 2: next-PC select from decoder (00 branch, 01 jump, 10 sequential, 11 halt).
- `BS` in 1: branch type from decoder (1 BNE, 0 BGE).
- `ALU_ZERO` in 1: ALU result == 0.
- `ALU_NEG` in 1: ALU result bit 31.
- `IMM` in 32: sign-extended immediate from extend unit.
- `ALU_RESULT` in 32: jump target (JAL/JALR).
- `INSTR` out 32: latched instruction.
- `INSTR_VALID` out 1: `INSTR` and the decoded fields are valid for decode/execute.
- `OP_CODE` out 7 (`INSTR[6:0]`), `RD` out 5 (`[11:7]`), `FUNCT_3` out 3 (`[14:12]`), `RS1` out 5 (`[19:15]`), `RS2` out 5 (`[24:20]`), `FUNCT_7` out 7 (`[31:25]`).
- `PC` out ADDR_W: address of the instruction in `INSTR`.
- `PC_PLUS4` out ADDR_W: `PC+4`, used for link writeback (DWS=10).
- `HALT` out 1: fetch stopped.

## Operation
- States: IDLE, FETCH, EXEC, HALTED. Encoded in a 2-bit register.
- IDLE → FETCH unconditionally on the next edge.
- FETCH:
  - `IMEM_REQ`=1, `IMEM_ADDR`=`PC`.
  - On an edge with `IMEM_ACK`=1, latch `IMEM_RDATA` into `INSTR` and go to EXEC.
  - Otherwise stay in FETCH with the request held.
- EXEC:
  - `INSTR_VALID`=1, `IMEM_REQ`=0.
  - On an edge with `EXEC_DONE`=1, load the next PC and go to FETCH. If `PCS`=11, go to HALTED instead.
- HALTED: terminal. Only `RST` exits.
- Next-PC rules, evaluated in EXEC with `EXEC_DONE`:
  - PCS=10: `PC+4`.
  - PCS=01: `{ALU_RESULT[ADDR_W-1:1],1'b0}`.
  - PCS=00, BS=1 (BNE): taken if `ALU_ZERO`=0.
  - PCS=00, BS=0 (BGE): taken if `ALU_NEG`=0. This uses the sign of the SUB result; overflow is not considered.
  - Taken branch → `PC+IMM[ADDR_W-1:0]`. Not taken → `PC+4`.
- All adds wrap modulo 2^ADDR_W. No overflow flag.
- `IMEM_ACK` outside FETCH is ignored. `EXEC_DONE` outside EXEC is ignored.
- Decoded fields are pure slices of `INSTR`. They are valid regardless of state but meaningful only while `INSTR_VALID`=1.

## Timing
- Reset values while `RST`=1 and on the first edge after:
  - State IDLE.
  - `PC`=`RESET_PC`, `PC_PLUS4`=`RESET_PC+4`.
  - `INSTR`=32'h0000_0013 (ADDI x0,x0,0), so the decoder sees a legal opcode.
  - `IMEM_REQ`=0, `INSTR_VALID`=0, `HALT`=0.
- The first `IMEM_REQ` is asserted in the second cycle after `RST` falls (IDLE, then FETCH).
- `IMEM_ACK` may arrive in the same cycle `IMEM_REQ` rises. This gives 1 fetch cycle plus ≥1 EXEC cycle, so the minimum is 2 cycles per instruction.
- `INSTR_VALID` rises on the edge that samples `IMEM_ACK`. It falls on the edge that samples `EXEC_DONE`.
- `PC` changes only on the EXEC edge that samples `EXEC_DONE`. `IMEM_ADDR` is stable for the whole FETCH.
- Reset mid-fetch or mid-exec: state, PC and `INSTR` return to reset values on that edge. A late `IMEM_ACK` arriving in IDLE is dropped.
- `RST` and `EXEC_DONE` on the same edge: reset wins.
- HALTED: `HALT`=1, `IMEM_REQ`=0, `INSTR_VALID`=0, PC frozen.

## Configuration
- `FETCH_MISALIGN_CHECK_EN` defined:
  - If the computed next PC has `[1:0]`≠00, enter HALTED instead of FETCH.
  - `PC` keeps the address of the offending instruction.
  - `HALT`=1 the following cycle.
- Undefined: next-PC bits `[1:0]` are forced to 00 and execution continues.

## Test plan
- Reset and sequential fetch: `RST` high 3 cycles, then low, memory acks immediately, 3 ADDI words, `EXEC_DONE` one cycle after each `INSTR_VALID` → `IMEM_ADDR` sequence 0x0, 0x4, 0x8. First `IMEM_REQ` occurs 2 cycles after `RST` falls.
- Memory wait states: ack delayed 4 cycles → `IMEM_REQ`/`IMEM_ADDR` held 5 cycles, `INSTR_VALID` stays low, `PC` unchanged.
- Branches at PC=0x10, IMM=0xFFFF_FFF8:
  - BNE with `ALU_ZERO`=0 → next PC 0x08.
  - BNE with `ALU_ZERO`=1 → 0x14.
  - BGE with `ALU_NEG`=1 → 0x14.
- Jump and wrap:
  - PCS=01, `ALU_RESULT`=0x0000_0101 → PC 0x100.
  - PC=0xFFFF_FFFC with PCS=10 → PC 0x0, `PC_PLUS4` 0x4.
- Reset mid-operation and halt:
  - `RST` asserted during FETCH with a pending ack → PC=`RESET_PC`, INSTR=0x13, ack ignored.
  - PCS=11 → `HALT`=1, no further `IMEM_REQ`.
- With `FETCH_MISALIGN_CHECK_EN`: branch to PC+0x2 → `HALT`=1, PC unchanged. Without the macro → PC advances to the aligned address.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// rtl/instr_fetch_unit.sv - PC ownership, request/ack instruction fetch, field split and next-PC select.
// Optional feature macro: FETCH_MISALIGN_CHECK_EN (halt on a misaligned next PC instead of forcing alignment).
module instr_fetch_unit #(
   parameter int unsigned        ADDR_W   = 32,
   parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
   input  logic              CLK,
   input  logic              RST,
   output logic              IMEM_REQ,
   output logic [ADDR_W-1:0] IMEM_ADDR,
   input  logic              IMEM_ACK,
   input  logic [31:0]       IMEM_RDATA,
   input  logic              EXEC_DONE,
   input  logic [1:0]        PCS,
   input  logic              BS,
   input  logic              ALU_ZERO,
   input  logic              ALU_NEG,
   input  logic [31:0]       IMM,
   input  logic [31:0]       ALU_RESULT,
   output logic [31:0]       INSTR,
   output logic              INSTR_VALID,
   output logic [6:0]        OP_CODE,
   output logic [4:0]        RD,
   output logic [2:0]        FUNCT_3,
   output logic [4:0]        RS1,
   output logic [4:0]        RS2,
   output logic [6:0]        FUNCT_7,
   output logic [ADDR_W-1:0] PC,
   output logic [ADDR_W-1:0] PC_PLUS4,
   output logic              HALT
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'b00,
      S_FETCH  = 2'b01,
      S_EXEC   = 2'b10,
      S_HALTED = 2'b11
   } state_t;

   // ADDI x0,x0,0 so the decoder always sees a legal opcode out of reset
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   state_t            state_q;
   logic [ADDR_W-1:0] pc_q;
   logic [31:0]       instr_q;
   logic              req_q;
   logic              valid_q;
   logic              halt_q;

   logic [ADDR_W-1:0] pc_seq;
   logic [ADDR_W-1:0] raw_pc;
   logic [ADDR_W-1:0] next_pc_d;
   logic              stop_d;
   logic              taken;
   logic              unused_alu_lsb;
`ifndef FETCH_MISALIGN_CHECK_EN
   logic [1:0]        unused_raw_low;
`endif

   // Jump targets always have bit 0 cleared (JALR semantics), so bit 0 of the ALU result is dropped
   assign unused_alu_lsb = ALU_RESULT[0];

   // Next-PC selection from decoder select, branch type and ALU flags; all adds wrap
   always_comb begin
      pc_seq    = pc_q + ADDR_W'(4);
      taken     = BS ? ~ALU_ZERO : ~ALU_NEG;
      raw_pc    = pc_seq;
      next_pc_d = pc_seq;
      stop_d    = 1'b0;
      case (PCS)
         2'b10:   raw_pc = pc_seq;
         2'b01:   raw_pc = {ALU_RESULT[ADDR_W-1:1], 1'b0};
         2'b00:   raw_pc = taken ? (pc_q + IMM[ADDR_W-1:0]) : pc_seq;
         default: raw_pc = pc_seq;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      // A misaligned target stops fetch and leaves PC pointing at the offending instruction
      next_pc_d = raw_pc;
      stop_d    = (PCS == 2'b11) || (raw_pc[1:0] != 2'b00);
`else
      // Without the check the low bits are simply dropped and execution carries on
      unused_raw_low = raw_pc[1:0];
      next_pc_d      = {raw_pc[ADDR_W-1:2], 2'b00};
      stop_d         = (PCS == 2'b11);
`endif
   end

   // Fetch/execute sequencer with registered handshake and status outputs
   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= S_IDLE;
         pc_q    <= RESET_PC;
         instr_q <= NOP_INSTR;
         req_q   <= 1'b0;
         valid_q <= 1'b0;
         halt_q  <= 1'b0;
      end else begin
         case (state_q)
            S_IDLE: begin
               state_q <= S_FETCH;
               req_q   <= 1'b1;
            end
            S_FETCH: begin
               if (IMEM_ACK) begin
                  instr_q <= IMEM_RDATA;
                  state_q <= S_EXEC;
                  req_q   <= 1'b0;
                  valid_q <= 1'b1;
               end
            end
            S_EXEC: begin
               if (EXEC_DONE) begin
                  valid_q <= 1'b0;
                  if (stop_d) begin
                     state_q <= S_HALTED;
                     halt_q  <= 1'b1;
                  end else begin
                     pc_q    <= next_pc_d;
                     state_q <= S_FETCH;
                     req_q   <= 1'b1;
                  end
               end
            end
            default: begin
               req_q   <= 1'b0;
               valid_q <= 1'b0;
               halt_q  <= 1'b1;
            end
         endcase
      end
   end

   assign IMEM_REQ    = req_q;
   assign IMEM_ADDR   = pc_q;
   assign INSTR       = instr_q;
   assign INSTR_VALID = valid_q;
   assign OP_CODE     = instr_q[6:0];
   assign RD          = instr_q[11:7];
   assign FUNCT_3     = instr_q[14:12];
   assign RS1         = instr_q[19:15];
   assign RS2         = instr_q[24:20];
   assign FUNCT_7     = instr_q[31:25];
   assign PC          = pc_q;
   assign PC_PLUS4    = pc_seq;
   assign HALT        = halt_q;

endmodule
